entity_table_ctrl: RTL

- Sits between game-logic requesters (player, enemies, projectiles, HUD) and the frame buffer's nine entity channels.
- Arbitrates writes from NUM_REQ requesters, round-robin, one write per cycle, into a shadow entity table.
- Commits the shadow table to the live table in one cycle at the start of vertical blanking. The frame buffer therefore never sees an entity change mid-frame.
- Drives the frame buffer's entity_1..entity_7, entity_8_Flip and entity_9_Flip inputs from the live table.

---
 rtl/entity_table_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/entity_table_ctrl.sv
// Entity table controller: round-robin write arbitration into a shadow table,
// with the whole table committed to the live outputs once per vertical blank.
module entity_table_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 9,
  parameter int unsigned ENTITY_W  = 14,
  parameter logic [3:0]  UNUSED_ID = 4'hf
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [4*NUM_REQ-1:0]          req_slot,
  input  logic [ENTITY_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          v_blank,
  output logic [ENTITY_W*NUM_SLOTS-1:0] entities_out,
  output logic                          commit_pulse,
  output logic                          slot_err
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [ENTITY_W-1:0] EMPTY_ENTRY = {UNUSED_ID, {(ENTITY_W-ID_W){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_COMMIT = 2'd1,
    ST_BLANK  = 2'd2
  } state_e;

  state_e                                  state_q, state_d;
  logic                                    vblank_prev_q;
  logic [PTR_W-1:0]                        ptr_q, ptr_d;
  logic [NUM_SLOTS-1:0][ENTITY_W-1:0]      shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0][ENTITY_W-1:0]      live_q, live_d;
  logic                                    commit_pulse_q, commit_pulse_d;
  logic                                    slot_err_q, slot_err_d;

  logic                                    grant_vld_c;
  logic [PTR_W-1:0]                        grant_idx_c;
  logic [SLOT_W-1:0]                       sel_slot_c;
  logic [ENTITY_W-1:0]                     sel_data_c;
  int unsigned                             rr_idx_c;
  logic                                    vblank_rise_c;

  assign vblank_rise_c = v_blank & ~vblank_prev_q;

  // Round-robin search starting one past the last granted requester; no grant in COMMIT.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = ptr_q;
    rr_idx_c    = 0;
    if (!reset && (state_q != ST_COMMIT)) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        rr_idx_c = (32'(ptr_q) + off) % NUM_REQ;
        if (!grant_vld_c && req_valid[rr_idx_c]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = PTR_W'(rr_idx_c);
        end
      end
    end
  end

  // Payload of the granted requester.
  always_comb begin
    sel_slot_c = '0;
    sel_data_c = '0;
    req_ready  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_vld_c && (grant_idx_c == PTR_W'(i))) begin
        sel_slot_c   = req_slot[SLOT_W*i +: SLOT_W];
        sel_data_c   = req_data[ENTITY_W*i +: ENTITY_W];
        req_ready[i] = 1'b1;
      end
    end
  end

  // Frame FSM next state plus shadow/live table updates.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    shadow_d       = shadow_q;
    live_d         = live_q;
    commit_pulse_d = 1'b0;
    slot_err_d     = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (vblank_rise_c) begin
          state_d        = ST_COMMIT;
          commit_pulse_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        live_d  = shadow_q;
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!v_blank) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    // Out-of-range slots still consume the grant but leave the table untouched.
    if (grant_vld_c) begin
      ptr_d = grant_idx_c;
      if (32'(sel_slot_c) < NUM_SLOTS) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          if (sel_slot_c == SLOT_W'(k)) begin
            shadow_d[k] = sel_data_c;
          end
        end
      end else begin
        slot_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_ACTIVE;
      vblank_prev_q  <= 1'b0;
      ptr_q          <= PTR_W'(NUM_REQ - 1);
      shadow_q       <= {NUM_SLOTS{EMPTY_ENTRY}};
      live_q         <= {NUM_SLOTS{EMPTY_ENTRY}};
      commit_pulse_q <= 1'b0;
      slot_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vblank_prev_q  <= v_blank;
      ptr_q          <= ptr_d;
      shadow_q       <= shadow_d;
      live_q         <= live_d;
      commit_pulse_q <= commit_pulse_d;
      slot_err_q     <= slot_err_d;
    end
  end

  assign entities_out = live_q;
  assign commit_pulse = commit_pulse_q;
  assign slot_err     = slot_err_q;

endmodule
